sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles from grant to completion before forced abort.
REQ-002 clk  in  1  single system clock, all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  instruction fetch request, held until i_ack.
REQ-005 i_addr  in  23  instruction word address.
REQ-006 i_data  out  32  fetched instruction {upper,lower}.
REQ-007 i_ack  out  1  one-cycle completion pulse for instruction port.
REQ-008 d_req  in  1  data request, held until d_ack.
REQ-009 d_we  in  1  1 = write, 0 = read.
REQ-010 d_addr  in  23  data word address.
REQ-011 d_wdata  in  16  write data.
REQ-012 d_rdata  out  16  read data.
REQ-013 d_ack  out  1  one-cycle completion pulse for data port.
REQ-014 err  out  1  one-cycle pulse, coincident with an ack, when a transaction aborted by timeout.
REQ-015 m_addr  out  23  address to SDRAM controller.
REQ-016 m_wdata  out  16  write data to SDRAM controller.
REQ-017 m_read_req / m_write_req  out  1 each  request strobes to SDRAM controller.
REQ-018 m_instruction_mode  out  1  1 = instruction-bank 32-bit read.
REQ-019 m_busy  in  1  controller busy.
REQ-020 m_read_ready  in  1  controller read data valid.
REQ-021 m_rdata  in  32  controller read data.

Function
REQ-022 FSM states IDLE, ISSUE, ACCEPT, COMPLETE, ACK; reset state IDLE.
REQ-023 IDLE: if any req, grant per REQ-024, latch address/data/we/mode, go ISSUE next cycle; otherwise stay.
REQ-024 Arbitration round-robin: both requesting -> grant port not granted last; last_grant resets to data, so instruction wins first tie.
REQ-025 ISSUE: assert m_read_req (instr, or data with d_we=0) or m_write_req (data with d_we=1) only while m_busy=0; exactly one strobe cycle, then go ACCEPT.
REQ-026 ACCEPT: wait for m_busy=1 (controller took request), then COMPLETE.
REQ-027 COMPLETE read: wait for m_read_ready=1, capture m_rdata (i_data all 32 bits; d_rdata = m_rdata[15:0]), go ACK; write: wait for m_busy=0, go ACK.
REQ-028 m_read_ready=1 and m_busy=0 in same cycle during COMPLETE read: capture data, single completion only.
REQ-029 ACK: pulse only granted port's ack for one cycle, return IDLE; req inputs ignored in ACK cycle (no back-to-back regrant without IDLE).
REQ-030 Grant-to-ack latency minimum 4 cycles plus controller latency.
REQ-031 m_addr, m_wdata, m_instruction_mode held stable from ISSUE through ACK; m_instruction_mode=1 only for instruction grants.
REQ-032 Timeout counter, width clog2(TIMEOUT_CYCLES+1), cleared at grant, increments in ACCEPT/COMPLETE; reaching TIMEOUT_CYCLES -> ACK with err=1, read data outputs unchanged.
REQ-033 i_data, d_rdata hold last captured value until next capture.
REQ-034 Requester dropping req before ack: transaction still completes, ack still pulsed.

Reset
REQ-035 rst=1 in any state: next cycle state IDLE, last_grant=data, timeout counter 0; i_ack, d_ack, err, m_read_req, m_write_req, m_instruction_mode =0; i_data, d_rdata, m_addr, m_wdata =0.
REQ-036 Reset mid-transaction issues no ack and no further strobe; controller-side completion after reset is ignored.

Structure
REQ-037 Package sdram_arb_pkg holds FSM state type, port-ID constants (PORT_INSTR, PORT_DATA), default TIMEOUT_CYCLES.
REQ-038 Sub-module sdram_arb_rr: two-input round-robin grant with last_grant register; rest in sdram_arbiter.

Verification
REQ-039 i_req, i_addr=0x000123, model returns m_rdata=0xBEEF1234 -> one m_read_req with m_instruction_mode=1, i_ack once, i_data=0xBEEF1234.
REQ-040 d_req, d_we=1, d_addr=0x7FFFFF, d_wdata=0xA5A5 -> one m_write_req, m_wdata=0xA5A5, d_ack after m_busy falls, i_ack stays 0.
REQ-041 i_req and d_req held continuously for 6 transactions -> grant order I,D,I,D,I,D.
REQ-042 TIMEOUT_CYCLES=8, model never asserts m_busy -> after 8 ACCEPT cycles ack with err=1, FSM IDLE.
REQ-043 rst during COMPLETE with later m_read_ready=1 -> no ack, outputs at reset values, next request serviced normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W  = 23;
  localparam int IDATA_W = 32;
  localparam int DDATA_W = 16;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_ACCEPT   = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_ACK      = 3'd4
  } state_t;

  typedef logic port_t;

  localparam port_t PORT_INSTR = 1'b0;
  localparam port_t PORT_DATA  = 1'b1;

  function automatic logic is_write(input port_t port, input logic we);
    return (port == PORT_DATA) && we;
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Requester ports and SDRAM-controller ports of the arbiter as one bundle.
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic [IDATA_W-1:0] i_data;
  logic               i_ack;

  logic               d_req;
  logic               d_we;
  logic [ADDR_W-1:0]  d_addr;
  logic [DDATA_W-1:0] d_wdata;
  logic [DDATA_W-1:0] d_rdata;
  logic               d_ack;

  logic               err;

  logic [ADDR_W-1:0]  m_addr;
  logic [DDATA_W-1:0] m_wdata;
  logic               m_read_req;
  logic               m_write_req;
  logic               m_instruction_mode;
  logic               m_busy;
  logic               m_read_ready;
  logic [IDATA_W-1:0] m_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  m_busy, m_read_ready, m_rdata,
    output i_data, i_ack, d_rdata, d_ack, err,
    output m_addr, m_wdata, m_read_req, m_write_req, m_instruction_mode
  );

  // Requesters plus controller, as seen from outside the arbiter.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output m_busy, m_read_ready, m_rdata,
    input  i_data, i_ack, d_rdata, d_ack, err,
    input  m_addr, m_wdata, m_read_req, m_write_req, m_instruction_mode
  );

endinterface

// File: rtl/sdram_arb_rr.sv
// Two-input round-robin grant; on a tie the port not granted last wins.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_instr,
  input  logic  req_data,
  input  logic  update,
  output port_t grant
);

  port_t last_grant_r;

  // Grant selection from the current requests and the previous winner.
  always_comb begin
    grant = PORT_INSTR;
    if (req_instr && req_data) begin
      grant = (last_grant_r == PORT_DATA) ? PORT_INSTR : PORT_DATA;
    end else if (req_data) begin
      grant = PORT_DATA;
    end else begin
      grant = PORT_INSTR;
    end
  end

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= PORT_DATA;
    end else if (update) begin
      last_grant_r <= grant;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one SDRAM
// controller, with a per-transaction timeout that forces completion.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic        clk,
  input logic        rst,
  sdram_arb_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_r;
  state_t             state_s;
  port_t              grant_s;
  port_t              port_r;
  logic               write_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               take_s;
  logic               strobe_s;
  logic               done_s;
  logic               timeout_s;
  logic               cnt_hit_s;
  logic               counting_s;

  logic [IDATA_W-1:0] i_data_r;
  logic [DDATA_W-1:0] d_rdata_r;
  logic               i_ack_r;
  logic               d_ack_r;
  logic               err_r;
  logic [ADDR_W-1:0]  m_addr_r;
  logic [DDATA_W-1:0] m_wdata_r;
  logic               mode_r;

  assign take_s     = (state_r == ST_IDLE) && (bus.i_req || bus.d_req);
  assign counting_s = (state_r == ST_ACCEPT) || (state_r == ST_COMPLETE);
  // >= rather than == so a counter that passed the limit in ACCEPT still aborts in COMPLETE.
  assign cnt_hit_s  = (cnt_r >= CNT_LAST);

  sdram_arb_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_instr (bus.i_req),
    .req_data  (bus.d_req),
    .update    (take_s),
    .grant     (grant_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the single-cycle request strobe.
  always_comb begin
    state_s   = state_r;
    strobe_s  = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!bus.m_busy) begin
          strobe_s = 1'b1;
          state_s  = ST_ACCEPT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ACCEPT: begin
        if (bus.m_busy) begin
          state_s = ST_COMPLETE;
        end else if (cnt_hit_s) begin
          timeout_s = 1'b1;
          state_s   = ST_ACK;
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_COMPLETE: begin
        // Reads finish on read_ready alone, so ready with busy low completes once.
        if (write_r ? !bus.m_busy : bus.m_read_ready) begin
          done_s  = 1'b1;
          state_s = ST_ACK;
        end else if (cnt_hit_s) begin
          timeout_s = 1'b1;
          state_s   = ST_ACK;
        end else begin
          state_s = ST_COMPLETE;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant latching, timeout counting, read capture and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_r    <= PORT_DATA;
      write_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      i_data_r  <= {IDATA_W{1'b0}};
      d_rdata_r <= {DDATA_W{1'b0}};
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      err_r     <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DDATA_W{1'b0}};
      mode_r    <= 1'b0;
    end else begin
      i_ack_r <= (done_s || timeout_s) && (port_r == PORT_INSTR);
      d_ack_r <= (done_s || timeout_s) && (port_r == PORT_DATA);
      err_r   <= timeout_s;
      if (take_s) begin
        port_r    <= grant_s;
        write_r   <= is_write(grant_s, bus.d_we);
        m_addr_r  <= (grant_s == PORT_INSTR) ? bus.i_addr : bus.d_addr;
        m_wdata_r <= (grant_s == PORT_DATA) ? bus.d_wdata : {DDATA_W{1'b0}};
        mode_r    <= (grant_s == PORT_INSTR);
        cnt_r     <= {CNT_W{1'b0}};
      end else if (counting_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (done_s && !write_r) begin
        if (port_r == PORT_INSTR) begin
          i_data_r <= bus.m_rdata;
        end else begin
          d_rdata_r <= bus.m_rdata[DDATA_W-1:0];
        end
      end
    end
  end

  assign bus.i_data             = i_data_r;
  assign bus.d_rdata            = d_rdata_r;
  assign bus.i_ack              = i_ack_r;
  assign bus.d_ack              = d_ack_r;
  assign bus.err                = err_r;
  assign bus.m_addr             = m_addr_r;
  assign bus.m_wdata            = m_wdata_r;
  assign bus.m_instruction_mode = mode_r;
  assign bus.m_read_req         = strobe_s && !write_r;
  assign bus.m_write_req        = strobe_s && write_r;

endmodule
